transmisor: RTL and testbench

Transmit-side PCS code-group generator for the 1000BASE-X link. Accepts GMII octets (TXD, TX_EN, TX_ER) and emits one 10-bit 8B/10B code group per clock: idle ordered sets when no frame is active, and /S/ data… /T/R/[R/] framing around each frame. It tracks running disparity and even/odd alignment so its output stream is accepted by the team's receive state machine.

---
 rtl/pcs_pkg.sv | 94 +++++++++
 rtl/pcs_8b10b_encoder.sv | 46 ++++
 rtl/transmisor.sv | 114 +++++++++++
 tb/tb_transmisor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS transmit definitions: code-group constants, octet values
// of the special groups, transmit FSM states and 8B/10B sub-block tables.
package pcs_pkg;

    // Code groups, abcdei fghj, RD- / RD+ forms
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] K27_7_RDN = 10'b1101101000;
    localparam logic [9:0] K27_7_RDP = 10'b0010010111;
    localparam logic [9:0] K29_7_RDN = 10'b1011101000;
    localparam logic [9:0] K29_7_RDP = 10'b0100010111;
    localparam logic [9:0] K23_7_RDN = 10'b1110101000;
    localparam logic [9:0] K23_7_RDP = 10'b0001010111;
    localparam logic [9:0] K30_7_RDN = 10'b0111101000;
    localparam logic [9:0] K30_7_RDP = 10'b1000010111;
    localparam logic [9:0] D5_6      = 10'b1010010110;
    localparam logic [9:0] D16_2_RDN = 10'b0110110101;
    localparam logic [9:0] D16_2_RDP = 10'b1001000101;

    // Octet values fed to the encoder for each special group
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_K27_7 = 8'hFB;
    localparam logic [7:0] OCT_K29_7 = 8'hFD;
    localparam logic [7:0] OCT_K23_7 = 8'hF7;
    localparam logic [7:0] OCT_K30_7 = 8'hFE;
    localparam logic [7:0] OCT_D5_6  = 8'hC5;
    localparam logic [7:0] OCT_D16_2 = 8'h50;

    // State names the class of the code group most recently emitted
    typedef enum logic [2:0] {
        ST_IDLE_K,
        ST_IDLE_D,
        ST_SOP,
        ST_DATA,
        ST_EOP_T,
        ST_EOP_R,
        ST_EOP_R2
    } tx_state_t;

    // D.x.7 takes the alternate A7 form to avoid a run of five equal bits
    function automatic logic use_alt7(input logic [4:0] x, input logic rd);
        if (rd)
            return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        else
            return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    endfunction

    function automatic logic [5:0] enc6_rdneg(input logic [4:0] x);
        logic [5:0] r;
        case (x)
            5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
            5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
            5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
            5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
            5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
            5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
            5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
            5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
            5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
            5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
            5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
            5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
            5'd30: r = 6'b011110;  default: r = 6'b101011;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] enc4_rdneg(input logic [2:0] y);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b1011;  3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
            3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;  default: r = 4'b1110;
        endcase
        return r;
    endfunction

    // K28.y fghj chosen by the disparity entering the whole group
    function automatic logic [3:0] k28_4b_rdneg(input logic [2:0] y);
        logic [3:0] r;
        case (y)
            3'd0: r = 4'b0100;  3'd1: r = 4'b1001;
            3'd2: r = 4'b0101;  3'd3: r = 4'b0011;
            3'd4: r = 4'b0010;  3'd5: r = 4'b1010;
            3'd6: r = 4'b0110;  default: r = 4'b1000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcs_8b10b_encoder.sv
// Combinational 8B/10B encoder for data (D.x.y) and control (K.x.y) octets,
// selecting the code-group form from the incoming running disparity.
module pcs_8b10b_encoder
    import pcs_pkg::*;
(
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic       is_k28;
    logic [5:0] c6n;
    logic [5:0] code6;
    logic [3:0] c4n;
    logic [3:0] code4;
    logic       bal6;
    logic       bal4;
    logic       rd_mid;

    assign x      = data[4:0];
    assign y      = data[7:5];
    assign is_k28 = is_k && (x == 5'd28);

    always_comb begin
        c6n = is_k28 ? 6'b001111 : enc6_rdneg(x);
        bal6 = ($countones(c6n) == 3);
        // D.7 is balanced yet still has distinct RD- and RD+ forms
        code6 = (rd_in && (!bal6 || x == 5'd7)) ? ~c6n : c6n;
        rd_mid = bal6 ? rd_in : ~rd_in;

        c4n = (y == 3'd7 && (is_k || use_alt7(x, rd_in))) ? 4'b0111 : enc4_rdneg(y);
        if (is_k28)
            code4 = rd_in ? ~k28_4b_rdneg(y) : k28_4b_rdneg(y);
        else
            code4 = (rd_mid && (($countones(c4n) != 2) || y == 3'd3)) ? ~c4n : c4n;

        bal4   = ($countones(code4) == 2);
        rd_out = bal4 ? rd_mid : ~rd_mid;
        code   = {code6, code4};
    end

endmodule

// File: rtl/transmisor.sv
// 1000BASE-X PCS transmit code-group generator: idle ordered sets and /S/../T/R/[R/]
// frame delimiting. Define PCS_TX_ERR_PROP_EN to propagate TX_ER as /V/.
module transmisor
    import pcs_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] TX_CODE_GROUP,
    output logic       TX_EVEN,
    output logic       TX_DISP
);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [7:0] enc_data;
    logic       enc_k;
    logic [9:0] enc_code;
    logic       enc_rd;

`ifndef PCS_TX_ERR_PROP_EN
    logic unused_tx_er;
    assign unused_tx_er = TX_ER;
`endif

    pcs_8b10b_encoder u_enc (
        .data   (enc_data),
        .is_k   (enc_k),
        .rd_in  (TX_DISP),
        .code   (enc_code),
        .rd_out (enc_rd)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE_K;
            TX_CODE_GROUP <= K28_5_RDN;
            TX_EVEN       <= 1'b1;
            TX_DISP       <= 1'b1;
        end else begin
            state         <= state_nxt;
            TX_CODE_GROUP <= enc_code;
            TX_EVEN       <= ~TX_EVEN;
            TX_DISP       <= enc_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        enc_data  = OCT_K28_5;
        enc_k     = 1'b1;
        case (state)
            ST_IDLE_K: begin
                // D16.2 after a K28.5 that left RD+ brings the idle back to RD-
                enc_data  = TX_DISP ? OCT_D16_2 : OCT_D5_6;
                enc_k     = 1'b0;
                state_nxt = ST_IDLE_D;
            end
            ST_IDLE_D: begin
                if (TX_EN) begin
                    enc_data  = OCT_K27_7;
                    state_nxt = ST_SOP;
                end else begin
                    enc_data  = OCT_K28_5;
                    state_nxt = ST_IDLE_K;
                end
            end
            ST_SOP, ST_DATA: begin
                if (!TX_EN) begin
                    enc_data  = OCT_K29_7;
                    state_nxt = ST_EOP_T;
                end else begin
                    state_nxt = ST_DATA;
`ifdef PCS_TX_ERR_PROP_EN
                    if (TX_ER) begin
                        enc_data = OCT_K30_7;
                    end else begin
                        enc_data = TXD;
                        enc_k    = 1'b0;
                    end
`else
                    enc_data = TXD;
                    enc_k    = 1'b0;
`endif
                end
            end
            ST_EOP_T: begin
                enc_data  = OCT_K23_7;
                state_nxt = ST_EOP_R;
            end
            ST_EOP_R: begin
                // TX_EVEN still describes the current slot, so low means the next one is even
                if (!TX_EVEN) begin
                    enc_data  = OCT_K28_5;
                    state_nxt = ST_IDLE_K;
                end else begin
                    enc_data  = OCT_K23_7;
                    state_nxt = ST_EOP_R2;
                end
            end
            ST_EOP_R2: begin
                enc_data  = OCT_K28_5;
                state_nxt = ST_IDLE_K;
            end
            default: begin
                enc_data  = OCT_K28_5;
                state_nxt = ST_IDLE_K;
            end
        endcase
    end

endmodule

// File: tb/tb_transmisor.sv
// Self-checking bench for transmisor: directed framing cases plus randomized frames
// checked against a slot-level reference model of the transmit code-group stream.
module tb_transmisor;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] TXD = 8'h00;
    logic       TX_EN = 1'b0;
    logic       TX_ER = 1'b0;
    logic [9:0] TX_CODE_GROUP;
    logic       TX_EVEN;
    logic       TX_DISP;

    transmisor dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .TX_CODE_GROUP (TX_CODE_GROUP),
        .TX_EVEN       (TX_EVEN),
        .TX_DISP       (TX_DISP)
    );

    always #5 CLK = ~CLK;

`ifdef PCS_TX_ERR_PROP_EN
    localparam bit ERR_PROP = 1'b1;
`else
    localparam bit ERR_PROP = 1'b0;
`endif

    localparam int K_K28 = 0, K_S = 1, K_T = 2, K_R = 3, K_V = 4;
    localparam logic [9:0] D21_2 = 10'b1010100101;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: output slot parity, running disparity, frame flag, pending tail groups
    bit         m_even;
    bit         m_rd;
    bit         in_frame;
    int         tail[$];
    logic [9:0] m_code;

    function automatic logic [9:0] kcode(input int kind, input bit rd);
        case (kind)
            K_K28:   return rd ? 10'b1100000101 : 10'b0011111010;
            K_S:     return rd ? 10'b0010010111 : 10'b1101101000;
            K_T:     return rd ? 10'b0100010111 : 10'b1011101000;
            K_R:     return rd ? 10'b0001010111 : 10'b1110101000;
            default: return rd ? 10'b1000010111 : 10'b0111101000;
        endcase
    endfunction

    function automatic logic [9:0] dcode(input logic [7:0] d, input bit rd);
        int         x = int'(d[4:0]);
        int         y = int'(d[7:5]);
        logic [5:0] s6 = T6[x];
        logic [3:0] s4 = T4[y];
        bit         rd1;
        if (rd && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
        rd1 = ($countones(s6) == 3) ? rd : !rd;
        if (y == 7 && ((!rd && (x == 17 || x == 18 || x == 20)) || (rd && (x == 11 || x == 13 || x == 14))))
            s4 = 4'b0111;
        if (rd1 && ($countones(s4) != 2 || y == 3)) s4 = ~s4;
        return {s6, s4};
    endfunction

    task automatic model_reset();
        m_even = 1'b1;
        m_rd = 1'b1;
        in_frame = 1'b0;
        tail.delete();
        m_code = 10'b0011111010;
    endtask

    task automatic model_step(input logic en, input logic er, input logic [7:0] d);
        bit ne = !m_even;
        if (tail.size() > 0) begin
            m_code = kcode(tail.pop_front(), m_rd);
        end else if (in_frame) begin
            if (!en) begin
                m_code = kcode(K_T, m_rd);
                in_frame = 1'b0;
                if (ne) tail = '{K_R, K_K28};
                else    tail = '{K_R, K_R, K_K28};
            end else if (er && ERR_PROP) begin
                m_code = kcode(K_V, m_rd);
            end else begin
                m_code = dcode(d, m_rd);
            end
        end else if (ne) begin
            if (en) begin
                m_code = kcode(K_S, m_rd);
                in_frame = 1'b1;
            end else begin
                m_code = kcode(K_K28, m_rd);
            end
        end else begin
            m_code = m_rd ? 10'b1001000101 : 10'b1010010110;
        end
        if ($countones(m_code) != 5) m_rd = !m_rd;
        m_even = ne;
    endtask

    task automatic tick(input logic en, input logic er, input logic [7:0] d);
        TX_EN = en;
        TX_ER = er;
        TXD = d;
        @(posedge CLK);
        #1;
        model_step(en, er, d);
    endtask

    task automatic idle_to_slot(input bit want_next_even);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'($urandom));
        if ((!m_even) != want_next_even) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        #1;
        n_cmp++;
        if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {10'b0011111010, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_value: got %b even=%b disp=%b, want 0011111010 even=1 disp=1",
                     TX_CODE_GROUP, TX_EVEN, TX_DISP);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            logic [9:0] want_c;
            logic       want_e;
            tick(1'b0, 1'b0, 8'($urandom));
            want_c = (i % 2 == 0) ? 10'b1001000101 : 10'b0011111010;
            want_e = (i % 2 == 1);
            n_cmp++;
            if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {want_c, want_e, want_e}) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got %b even=%b disp=%b, want %b even=%b disp=%b",
                         i, TX_CODE_GROUP, TX_EVEN, TX_DISP, want_c, want_e, want_e);
            end
        end
    endtask

    task automatic test_frame(input bit start_even);
        logic [7:0] oct[$];
        int         n55 = 0;
        int         want55;
        bit         saw_s = 1'b0;
        for (int i = 0; i < 7; i++) oct.push_back(8'h55);
        oct.push_back(8'hD5);
        oct.push_back(8'h1B);
        oct.push_back(8'h1C);
        idle_to_slot(start_even);
        for (int i = 0; i < oct.size() + 6; i++) begin
            bit en = (i < oct.size());
            tick(en, 1'b0, en ? oct[i] : 8'h00);
            if (TX_CODE_GROUP === D21_2) n55++;
            if (TX_CODE_GROUP === 10'b1101101000) saw_s = 1'b1;
            n_cmp++;
            if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {m_code, m_even, m_rd}) begin
                n_bad++;
                $display("FAIL frame_%s[%0d]: got %b even=%b disp=%b, want %b even=%b disp=%b",
                         start_even ? "even" : "odd", i, TX_CODE_GROUP, TX_EVEN, TX_DISP,
                         m_code, m_even, m_rd);
            end
        end
        want55 = start_even ? 6 : 5;
        n_cmp++;
        if (n55 !== want55 || !saw_s) begin
            n_bad++;
            $display("FAIL preamble_%s: got %0d x 0x55, sof_seen=%0d, want %0d x 0x55, sof_seen=1",
                     start_even ? "even" : "odd", n55, saw_s, want55);
        end
    endtask

    task automatic test_tail(input int len);
        idle_to_slot(1'b1);
        for (int i = 0; i < len + 10; i++) begin
            bit en = (i != len);
            logic [9:0] prev = TX_CODE_GROUP;
            tick(en, 1'b0, 8'($urandom));
            n_cmp++;
            if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {m_code, m_even, m_rd}) begin
                n_bad++;
                $display("FAIL tail_len%0d[%0d]: got %b even=%b disp=%b, want %b even=%b disp=%b",
                         len, i, TX_CODE_GROUP, TX_EVEN, TX_DISP, m_code, m_even, m_rd);
            end
            if (prev === 10'b1011101000 || prev === 10'b0100010111) begin
                n_cmp++;
                if (TX_CODE_GROUP !== 10'b1110101000 && TX_CODE_GROUP !== 10'b0001010111) begin
                    n_bad++;
                    $display("FAIL tail_r_after_t_len%0d: got %b, want /R/", len, TX_CODE_GROUP);
                end
            end
        end
    endtask

    task automatic test_error();
        idle_to_slot(1'b1);
        for (int i = 0; i < 16; i++) begin
            bit en = (i < 10);
            bit er = (i == 4) || (i == 7) || (i == 10) || (i == 13);
            tick(en, er, 8'($urandom));
            n_cmp++;
            if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {m_code, m_even, m_rd}) begin
                n_bad++;
                $display("FAIL tx_er[%0d]: got %b even=%b disp=%b, want %b even=%b disp=%b",
                         i, TX_CODE_GROUP, TX_EVEN, TX_DISP, m_code, m_even, m_rd);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int gap = $urandom_range(0, 5);
            int len = $urandom_range(1, 20);
            for (int i = 0; i < gap + len; i++) begin
                bit         en = (i >= gap);
                bit         er = ($urandom_range(0, 7) == 0);
                logic [9:0] prev = TX_CODE_GROUP;
                tick(en, er, 8'($urandom));
                n_cmp++;
                if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {m_code, m_even, m_rd}) begin
                    n_bad++;
                    $display("FAIL random f%0d c%0d: got %b even=%b disp=%b, want %b even=%b disp=%b",
                             f, i, TX_CODE_GROUP, TX_EVEN, TX_DISP, m_code, m_even, m_rd);
                end
                if (TX_CODE_GROUP === 10'b0011111010 || TX_CODE_GROUP === 10'b1100000101) begin
                    n_cmp++;
                    if (TX_EVEN !== 1'b1) begin
                        n_bad++;
                        $display("FAIL k28_alignment f%0d c%0d: got even=%b, want 1", f, i, TX_EVEN);
                    end
                end
                if ((prev === 10'b0011111010 || prev === 10'b1100000101) && !TX_EVEN) begin
                    n_cmp++;
                    if (TX_DISP !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle_disp f%0d c%0d: got disp=%b, want 0", f, i, TX_DISP);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit saw_t = 1'b0;
        idle_to_slot(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'($urandom));
        #2 RESET = 1'b1;
        #1;
        n_cmp++;
        if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {10'b0011111010, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL midframe_reset_async: got %b even=%b disp=%b, want 0011111010 even=1 disp=1",
                     TX_CODE_GROUP, TX_EVEN, TX_DISP);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {10'b0011111010, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL midframe_reset_held: got %b even=%b disp=%b, want 0011111010 even=1 disp=1",
                     TX_CODE_GROUP, TX_EVEN, TX_DISP);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 8'($urandom));
            if (TX_CODE_GROUP === 10'b1011101000 || TX_CODE_GROUP === 10'b0100010111) saw_t = 1'b1;
            n_cmp++;
            if ({TX_CODE_GROUP, TX_EVEN, TX_DISP} !== {m_code, m_even, m_rd}) begin
                n_bad++;
                $display("FAIL after_reset[%0d]: got %b even=%b disp=%b, want %b even=%b disp=%b",
                         i, TX_CODE_GROUP, TX_EVEN, TX_DISP, m_code, m_even, m_rd);
            end
        end
        n_cmp++;
        if (saw_t) begin
            n_bad++;
            $display("FAIL after_reset_no_t: got /T/ seen=1, want 0");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_frame(1'b1);
        test_frame(1'b0);
        test_tail(3);
        test_tail(4);
        test_error();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
